seq_det_ctrl: RTL and testbench

Run controller for a serial 11010 pattern detector. It arms an embedded overlapping Mealy detector on a start request and feeds it gated serial bits. It counts matches up to a programmed target and ends the run with a done or timeout pulse. It sits between the serial bit source and the software/status logic that schedules detection runs.

---
 rtl/seq_det_ctrl_if.sv | 28 ++
 rtl/seq_det_ctrl.sv | 135 +++++++++++++
 tb/tb_seq_det_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Bundle of run-control, serial-bit and status signals between the bit source /
// scheduler and the 11010 detector run controller.
interface seq_det_ctrl_if #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] target;
   logic [WIN_W-1:0] window;
   logic             in;
   logic             valid_in;
   logic             det;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output start, abort, target, window, in, valid_in,
      input  det, busy, done, timeout, match_cnt
   );

   modport slave (
      input  start, abort, target, window, in, valid_in,
      output det, busy, done, timeout, match_cnt
   );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run controller wrapping an overlapping Mealy 11010 detector: counts matches up
// to a latched target and ends each run with a done or timeout pulse.
module seq_det_ctrl #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) (
   input logic           clk,
   input logic           rst,
   seq_det_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE,
      TOUT
   } state_t;

   // Detector state = length of the 11010 prefix matched so far.
   typedef enum logic [2:0] {
      S0,
      S1,
      S2,
      S3,
      S4
   } det_state_t;

   state_t           state;
   det_state_t       det_state;
   det_state_t       det_next;
   logic             busy_q;
   logic             done_q;
   logic             timeout_q;
   logic [CNT_W-1:0] match_cnt_q;
   logic [WIN_W-1:0] bit_cnt;
   logic [CNT_W-1:0] target_q;
   logic [WIN_W-1:0] window_q;

   logic             step;
   logic             det_w;
   logic [CNT_W-1:0] match_inc;
   logic [WIN_W-1:0] bit_inc;
   logic             hit_target;
   logic             hit_window;

   // A bit is consumed only while running, qualified, and not being discarded by abort.
   assign step       = (state == RUN) && bus.valid_in && !bus.abort;
   assign det_w      = step && (det_state == S4) && !bus.in;
   assign match_inc  = match_cnt_q + 1'b1;
   assign bit_inc    = bit_cnt + 1'b1;
   assign hit_target = det_w && (match_inc == target_q);
   assign hit_window = (window_q != '0) && (bit_inc == window_q);

   // NOTE: every combinational output gets a default before the case so no latch is inferred.
   always_comb begin
      det_next = S0;
      unique case (det_state)
         S0:      det_next = bus.in ? S1 : S0;
         S1:      det_next = bus.in ? S2 : S0;
         S2:      det_next = bus.in ? S2 : S3;
         S3:      det_next = bus.in ? S4 : S0;
         S4:      det_next = bus.in ? S2 : S0;
         default: det_next = S0;
      endcase
   end

   // NOTE: reset is synchronous and clears every state register, including the latched run setup.
   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         det_state   <= S0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         match_cnt_q <= '0;
         bit_cnt     <= '0;
         target_q    <= '0;
         window_q    <= '0;
      end else begin
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  target_q    <= bus.target;
                  window_q    <= bus.window;
                  match_cnt_q <= '0;
                  bit_cnt     <= '0;
                  det_state   <= S0;
                  if (bus.target == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (bus.valid_in) begin
                  det_state <= det_next;
                  bit_cnt   <= bit_inc;
                  if (det_w) begin
                     match_cnt_q <= match_inc;
                  end
                  // Target completion wins over window expiry on the same bit.
                  if (hit_target) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                  end else if (hit_window) begin
                     state     <= TOUT;
                     timeout_q <= 1'b1;
                     busy_q    <= 1'b0;
                  end
               end
            end
            DONE:    state <= IDLE;
            TOUT:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.det       = det_w;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.timeout   = timeout_q;
   assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: per-cycle expectations are queued as stimulus
// is driven and popped at the falling edge when the DUT outputs are sampled.
module tb_seq_det_ctrl;

   localparam int CNT_W = 8;
   localparam int WIN_W = 16;

   typedef struct {
      string            tag;
      logic             det;
      logic             busy;
      logic             done;
      logic             timeout;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   logic rst_v;
   logic [CNT_W-1:0] tgt;
   logic [WIN_W-1:0] win;
   int total;
   int bad;
   exp_t sb[$];

   seq_det_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

   seq_det_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the rising edge, queue what the
   // outputs must be in this cycle, then sample and compare at the falling edge.
   task automatic cyc(input string tag, input logic st, input logic ab, input logic b,
                      input logic v, input logic e_det, input logic e_busy,
                      input logic e_done, input logic e_to, input logic [CNT_W-1:0] e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst          = rst_v;
      bus.start    = st;
      bus.abort    = ab;
      bus.in       = b;
      bus.valid_in = v;
      bus.target   = tgt;
      bus.window   = win;
      e.tag = tag; e.det = e_det; e.busy = e_busy; e.done = e_done;
      e.timeout = e_to; e.cnt = e_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check({e.tag, "_det"},     32'(bus.det),       32'(e.det));
      check({e.tag, "_busy"},    32'(bus.busy),      32'(e.busy));
      check({e.tag, "_done"},    32'(bus.done),      32'(e.done));
      check({e.tag, "_timeout"}, 32'(bus.timeout),   32'(e.timeout));
      check({e.tag, "_cnt"},     32'(bus.match_cnt), 32'(e.cnt));
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; rst_v = 1'b0;
      tgt = '0; win = '0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.in = 1'b0; bus.valid_in = 1'b0;
      bus.target = '0; bus.window = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_det",     32'(bus.det),       0);
      check("reset_busy",    32'(bus.busy),      0);
      check("reset_done",    32'(bus.done),      0);
      check("reset_timeout", 32'(bus.timeout),   0);
      check("reset_cnt",     32'(bus.match_cnt), 0);

      // Basic match, then a start during the DONE cycle must be ignored.
      tgt = 1; win = 0;
      cyc("t1_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t1_b1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t1_b2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t1_b3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t1_b4",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t1_b5",    0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t1_done",  1, 0, 0, 0, 0, 0, 1, 0, 1);
      cyc("t1_idle",  0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Overlap / prefix handling: matches on bits 6 and 11.
      tgt = 2; win = 0;
      cyc("t2_start", 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("t2_b1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t2_b2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t2_b3",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t2_b4",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t2_b5",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t2_b6",    0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t2_b7",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t2_b8",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t2_b9",    0, 0, 0, 1, 0, 1, 0, 0, 1);
      cyc("t2_b10",   0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t2_b11",   0, 0, 0, 1, 1, 1, 0, 0, 1);
      cyc("t2_done",  0, 0, 0, 0, 0, 0, 1, 0, 2);

      // Timeout: window=4 runs out before a match; start on the IDLE cycle after DONE.
      tgt = 1; win = 4;
      cyc("t3_start", 1, 0, 0, 0, 0, 0, 0, 0, 2);
      cyc("t3_b1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t3_b2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t3_b3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t3_b4",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t3_tout",  0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("t3_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Match and window expiry on the same bit: done wins.
      tgt = 1; win = 5;
      cyc("t3b_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t3b_b1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t3b_b2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t3b_b3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t3b_b4",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t3b_b5",    0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t3b_done",  0, 0, 0, 0, 0, 0, 1, 0, 1);

      // Gaps with in toggling while valid_in=0.
      tgt = 1; win = 0;
      cyc("t4_start", 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("t4_v1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t4_g1",    0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("t4_v2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t4_g2",    0, 0, 1, 0, 0, 1, 0, 0, 0);
      cyc("t4_v3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t4_g3",    0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("t4_g4",    0, 0, 1, 0, 0, 1, 0, 0, 0);
      cyc("t4_v4",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t4_g5",    0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("t4_v5",    0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t4_done",  0, 0, 0, 0, 0, 0, 1, 0, 1);

      // Gap cycles must not advance the window count: timeout after the third valid bit.
      tgt = 1; win = 3;
      cyc("t4b_start", 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("t4b_v1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t4b_g1",    0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("t4b_g2",    0, 0, 1, 0, 0, 1, 0, 0, 0);
      cyc("t4b_v2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t4b_g3",    0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("t4b_g4",    0, 0, 1, 0, 0, 1, 0, 0, 0);
      cyc("t4b_v3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t4b_tout",  0, 0, 0, 0, 0, 0, 0, 1, 0);

      // Abort after one match and a further 1101 prefix; the aborted 0 is discarded.
      tgt = 2; win = 0;
      cyc("t5_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t5_b1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t5_b2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t5_b3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t5_b4",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t5_b5",    0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t5_b6",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t5_b7",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t5_b8",    0, 0, 0, 1, 0, 1, 0, 0, 1);
      cyc("t5_b9",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t5_abort", 0, 1, 0, 1, 0, 1, 0, 0, 1);
      cyc("t5_idle1", 0, 0, 0, 1, 0, 0, 0, 0, 1);
      cyc("t5_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Detector was left at S4 by the abort; a new start must restart it from S0.
      tgt = 1; win = 0;
      cyc("t6_start", 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("t6_b1",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t6_b2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t6_b3",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t6_b4",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t6_b5",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t6_b6",    0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t6_done",  0, 0, 0, 0, 0, 0, 1, 0, 1);

      // Reset in the middle of a run with one match counted.
      tgt = 3; win = 0;
      cyc("t7_start", 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("t7_b1",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t7_b2",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t7_b3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t7_b4",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t7_b5",    0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t7_b6",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t7_b7",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t7_b8",    0, 0, 0, 1, 0, 1, 0, 0, 1);
      cyc("t7_b9",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      rst_v = 1'b1;
      cyc("t7_rst",   0, 0, 0, 0, 0, 1, 0, 0, 1);
      rst_v = 1'b0;
      cyc("t7_post",  0, 0, 0, 1, 0, 0, 0, 0, 0);
      tgt = 1;
      cyc("t7_rstart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t7_r1",     0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t7_r2",     0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t7_r3",     0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t7_r4",     0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t7_r5",     0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t7_r6",     0, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t7_rdone",  0, 0, 0, 0, 0, 0, 1, 0, 1);

      // target=0: immediate done, busy never rises, count cleared.
      tgt = 0; win = 0;
      cyc("t8_start", 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("t8_done",  0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc("t8_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0);

      // start with a different target/window during RUN must not disturb the run.
      tgt = 2; win = 0;
      cyc("t9_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tgt = 1; win = 3;
      cyc("t9_b1",    1, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t9_b2",    1, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t9_b3",    0, 0, 0, 1, 0, 1, 0, 0, 0);
      cyc("t9_b4",    0, 0, 1, 1, 0, 1, 0, 0, 0);
      cyc("t9_b5",    1, 0, 0, 1, 1, 1, 0, 0, 0);
      cyc("t9_b6",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t9_b7",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t9_b8",    0, 0, 0, 1, 0, 1, 0, 0, 1);
      cyc("t9_b9",    0, 0, 1, 1, 0, 1, 0, 0, 1);
      cyc("t9_b10",   0, 0, 0, 1, 1, 1, 0, 0, 1);
      cyc("t9_done",  0, 0, 0, 0, 0, 0, 1, 0, 2);
      cyc("t9_idle",  0, 0, 0, 0, 0, 0, 0, 0, 2);

      check("sb_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
